// File: rtl/collatz_sweep_ctrl.sv
// Host sequencer for the Collatz core: loads each seed over the IO-mode pins,
// runs it, reads back orbit/path and keeps the longest-orbit seed of the sweep.
//
// state   | meaning
// IDLE    | waiting for start after reset
// WR      | writing seed bytes 0..3
// GO      | one-cycle go strobe, clears timeout counter
// WAIT_C  | waiting for core to enter COMPUTE
// WAIT_IO | waiting for core to return to IO
// RD      | six 2-cycle reads: orbit[1:0], path[3:0]
// UPD     | orbit delta, overflow check, best tracking
// DONE    | sweep finished, waiting for start
// ERR     | overflow or timeout, only reset exits
module collatz_sweep_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TO_BITS        = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed_first,
  input  logic [31:0] seed_last,
  output logic [7:0]  core_ui_in,
  output logic [7:0]  core_uio_in,
  input  logic [7:0]  core_uo_out,
  input  logic [7:0]  core_uio_oe,
  output logic        busy,
  output logic        done,
  output logic [31:0] cur_seed,
  output logic [31:0] best_seed,
  output logic [15:0] best_len,
  output logic [31:0] best_peak,
  output logic        err_overflow,
  output logic        err_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR, S_GO, S_WAIT_C, S_WAIT_IO, S_RD, S_UPD, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                phase_q, phase_d;
  logic [31:0]         last_q, last_d;
  logic [31:0]         cur_seed_q, cur_seed_d;
  logic [31:0]         best_seed_q, best_seed_d;
  logic [15:0]         best_len_q, best_len_d;
  logic [31:0]         best_peak_q, best_peak_d;
  logic [15:0]         orbit_raw_q, orbit_raw_d;
  logic [31:0]         path_q, path_d;
  logic [15:0]         prev_raw_q, prev_raw_d;
  logic                first_q, first_d;
  logic [TO_BITS-1:0]  to_cnt_q, to_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_overflow_q, err_overflow_d;
  logic                err_timeout_q, err_timeout_d;
  logic [7:0]          core_ui_in_q, core_ui_in_d;
  logic [7:0]          core_uio_in_q, core_uio_in_d;
  logic [15:0]         run_len;
  logic                unused_oe;

  assign unused_oe = ^core_uio_oe[6:0];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_d        = phase_q;
    last_d         = last_q;
    cur_seed_d     = cur_seed_q;
    best_seed_d    = best_seed_q;
    best_len_d     = best_len_q;
    best_peak_d    = best_peak_q;
    orbit_raw_d    = orbit_raw_q;
    path_d         = path_q;
    prev_raw_d     = prev_raw_q;
    first_d        = first_q;
    to_cnt_d       = to_cnt_q;
    busy_d         = busy_q;
    done_d         = done_q;
    err_overflow_d = err_overflow_q;
    err_timeout_d  = err_timeout_q;
    core_ui_in_d   = 8'h00;
    core_uio_in_d  = 8'h00;
    // the core's orbit counter accumulates across runs, so each run is a delta
    run_len        = orbit_raw_q - prev_raw_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cur_seed_d  = seed_first;
          last_d      = seed_last;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          best_seed_d = '0;
          best_len_d  = '0;
          best_peak_d = '0;
          first_d     = 1'b1;
          idx_d       = 3'd0;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (idx_q == 3'd3) begin
          idx_d   = 3'd0;
          state_d = S_GO;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_GO: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_C;
      end
      S_WAIT_C, S_WAIT_IO: begin
        if (to_cnt_q >= TO_BITS'(TIMEOUT_CYCLES)) begin
          err_timeout_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_BITS'(1);
          if (state_q == S_WAIT_C && core_uio_oe[7]) begin
            state_d = S_WAIT_IO;
          end else if (state_q == S_WAIT_IO && !core_uio_oe[7]) begin
            idx_d   = 3'd0;
            phase_d = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          case (idx_q)
            3'd0:    orbit_raw_d[7:0]  = core_uo_out;
            3'd1:    orbit_raw_d[15:8] = core_uo_out;
            3'd2:    path_d[7:0]       = core_uo_out;
            3'd3:    path_d[15:8]      = core_uo_out;
            3'd4:    path_d[23:16]     = core_uo_out;
            default: path_d[31:24]     = core_uo_out;
          endcase
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = S_UPD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_UPD: begin
        prev_raw_d = orbit_raw_q;
        if (path_q == 32'hBAAD_F00D) begin
          err_overflow_d = 1'b1;
          busy_d         = 1'b0;
          state_d        = S_ERR;
        end else begin
          if (first_q || run_len > best_len_q) begin
            best_seed_d = cur_seed_q;
            best_len_d  = run_len;
            best_peak_d = path_q;
          end
          first_d = 1'b0;
          // >= rather than == so a reversed range stops after seed_first
          if (cur_seed_q >= last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            cur_seed_d = cur_seed_q + 32'd1;
            idx_d      = 3'd0;
            state_d    = S_WR;
          end
        end
      end
      S_ERR: ;
      default: state_d = S_IDLE;
    endcase

    // pin outputs follow the state being entered so they are valid throughout it
    case (state_d)
      S_WR: begin
        core_ui_in_d  = cur_seed_d[{idx_d[1:0], 3'b000} +: 8];
        core_uio_in_d = {6'b100000, idx_d[1:0]};
      end
      S_GO: core_uio_in_d = 8'h40;
      S_RD: core_uio_in_d = (idx_d < 3'd2) ? {7'b0, idx_d[0]}
                                           : {6'b000100, idx_d[1:0] - 2'd2};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      phase_q        <= 1'b0;
      last_q         <= '0;
      cur_seed_q     <= '0;
      best_seed_q    <= '0;
      best_len_q     <= '0;
      best_peak_q    <= '0;
      orbit_raw_q    <= '0;
      path_q         <= '0;
      prev_raw_q     <= '0;
      first_q        <= 1'b0;
      to_cnt_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      core_ui_in_q   <= '0;
      core_uio_in_q  <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      phase_q        <= phase_d;
      last_q         <= last_d;
      cur_seed_q     <= cur_seed_d;
      best_seed_q    <= best_seed_d;
      best_len_q     <= best_len_d;
      best_peak_q    <= best_peak_d;
      orbit_raw_q    <= orbit_raw_d;
      path_q         <= path_d;
      prev_raw_q     <= prev_raw_d;
      first_q        <= first_d;
      to_cnt_q       <= to_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
      core_ui_in_q   <= core_ui_in_d;
      core_uio_in_q  <= core_uio_in_d;
    end
  end

  assign core_ui_in   = core_ui_in_q;
  assign core_uio_in  = core_uio_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cur_seed     = cur_seed_q;
  assign best_seed    = best_seed_q;
  assign best_len     = best_len_q;
  assign best_peak    = best_peak_q;
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Bench for collatz_sweep_ctrl: behavioural Collatz core on the pins, plus a
// running best-orbit model checked against the DUT as the sweep advances.
module tb_collatz_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed_first = '0;
  logic [31:0] seed_last = '0;
  logic [7:0]  core_ui_in, core_uio_in, core_uo_out, core_uio_oe;
  logic        busy, done, err_overflow, err_timeout;
  logic [31:0] cur_seed, best_seed, best_peak;
  logic [15:0] best_len;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  collatz_sweep_ctrl #(.TIMEOUT_CYCLES(1000), .TO_BITS(11)) dut (
    .clk(clk), .reset(reset), .start(start),
    .seed_first(seed_first), .seed_last(seed_last),
    .core_ui_in(core_ui_in), .core_uio_in(core_uio_in),
    .core_uo_out(core_uo_out), .core_uio_oe(core_uio_oe),
    .busy(busy), .done(done), .cur_seed(cur_seed),
    .best_seed(best_seed), .best_len(best_len), .best_peak(best_peak),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  // Collatz orbit: steps until reaching 1 (at least one step), peak includes seed.
  function automatic void collatz(input logic [31:0] s, output int steps,
                                  output logic [31:0] peak, output bit ovf);
    longint unsigned n;
    n = s; steps = 0; peak = s; ovf = 0;
    if (s == 0) return;
    do begin
      if (n[0]) n = 3 * n + 1; else n = n >> 1;
      if (n > 64'hFFFF_FFFF) begin ovf = 1; return; end
      steps++;
      if (n > {32'b0, peak}) peak = n[31:0];
    end while (n != 1 && steps < 100000);
  endfunction

  function automatic int c_steps(input logic [31:0] s);
    int st; logic [31:0] pk; bit ov;
    collatz(s, st, pk, ov);
    return st;
  endfunction

  function automatic logic [31:0] c_peak(input logic [31:0] s);
    int st; logic [31:0] pk; bit ov;
    collatz(s, st, pk, ov);
    return pk;
  endfunction

  function automatic bit c_ovf(input logic [31:0] s);
    int st; logic [31:0] pk; bit ov;
    collatz(s, st, pk, ov);
    return ov;
  endfunction

  // Core model: cumulative orbit counter, registered read data, seed 0 hangs.
  logic [31:0] m_seed, m_path;
  logic [15:0] m_orbit;
  logic        m_comp, m_hang;
  int          m_cnt;
  logic [7:0]  m_uo;

  always @(posedge clk) begin
    if (reset) begin
      m_seed <= '0; m_path <= '0; m_orbit <= '0;
      m_comp <= 1'b0; m_hang <= 1'b0; m_cnt <= 0; m_uo <= '0;
    end else begin
      if (m_comp) begin
        if (!m_hang) begin
          if (m_cnt == 0) m_comp <= 1'b0;
          else m_cnt <= m_cnt - 1;
        end
      end else begin
        if (core_uio_in[7]) m_seed[8*core_uio_in[1:0] +: 8] <= core_ui_in;
        if (core_uio_in[6]) begin
          m_comp  <= 1'b1;
          m_hang  <= (m_seed == 32'd0);
          m_cnt   <= c_steps(m_seed) + 2;
          m_orbit <= m_orbit + 16'(c_steps(m_seed));
          m_path  <= c_ovf(m_seed) ? 32'hBAAD_F00D : c_peak(m_seed);
        end
      end
      m_uo <= core_uio_in[4] ? m_path[8*core_uio_in[1:0] +: 8]
                             : (core_uio_in[0] ? m_orbit[15:8] : m_orbit[7:0]);
    end
  end

  assign core_uo_out = m_uo;
  assign core_uio_oe = {m_comp, 7'h2A};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Running best over the seeds the DUT has finished in this sweep.
  logic        bp = 1'b0, dp = 1'b0;
  logic [31:0] prev_s = '0, rb_seed = '0, rb_peak = '0;
  int          rb_n = 0, rb_len = 0, f_len = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        bp = 1'b0; dp = 1'b0;
      end else begin
        if (busy && !bp) begin
          prev_s = cur_seed; rb_n = 0;
        end else if (bp && (cur_seed != prev_s || (done && !dp))) begin
          f_len = c_steps(prev_s);
          if (rb_n == 0 || f_len > rb_len) begin
            rb_seed = prev_s; rb_len = f_len; rb_peak = c_peak(prev_s);
          end
          rb_n++;
          if (busy) chk("seed_increment", cur_seed, prev_s + 32'd1);
          chk("run_best_seed", best_seed, rb_seed);
          chk("run_best_len", best_len, 64'(rb_len));
          chk("run_best_peak", best_peak, rb_peak);
          prev_s = cur_seed;
        end
        bp = busy; dp = done;
      end
    end
  end

  task automatic do_start(input logic [31:0] f, input logic [31:0] l);
    @(negedge clk);
    seed_first = f; seed_last = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    chk("idle_within_budget", busy, 0);
  endtask

  task automatic wait_oe(input logic lvl, input int budget);
    int k = 0;
    while (core_uio_oe[7] !== lvl && k < budget) begin @(negedge clk); k++; end
    chk("core_mode_within_budget", core_uio_oe[7], lvl);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ui_in"}, core_ui_in, 0);
    chk({tag, "_uio_in"}, core_uio_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cur_seed"}, cur_seed, 0);
    chk({tag, "_best_seed"}, best_seed, 0);
    chk({tag, "_best_len"}, best_len, 0);
    chk({tag, "_best_peak"}, best_peak, 0);
    chk({tag, "_err_ovf"}, err_overflow, 0);
    chk({tag, "_err_to"}, err_timeout, 0);
  endtask

  task automatic run_sweep(input logic [31:0] f, input logic [31:0] l);
    logic [31:0] stop, e_seed, e_peak;
    int e_len, n;
    do_start(f, l);
    wait_idle(30000);
    stop = (l < f) ? f : l;
    e_len = -1; e_seed = '0; e_peak = '0;
    for (longint x = f; x <= stop; x++) begin
      n = c_steps(32'(x));
      if (n > e_len) begin e_len = n; e_seed = 32'(x); e_peak = c_peak(32'(x)); end
    end
    chk("sweep_done", done, 1);
    chk("sweep_cur_seed", cur_seed, stop);
    chk("sweep_best_seed", best_seed, e_seed);
    chk("sweep_best_len", best_len, 64'(e_len));
    chk("sweep_best_peak", best_peak, e_peak);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f;
    int k;
    chk("model_steps_27", c_steps(32'd27), 111);
    chk("model_peak_27", c_peak(32'd27), 9232);
    chk("model_steps_1", c_steps(32'd1), 3);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("reset");

    run_sweep(32'd3, 32'd3);
    chk("s33_best_seed", best_seed, 3);
    chk("s33_best_len", best_len, 7);
    chk("s33_best_peak", best_peak, 16);

    run_sweep(32'd3, 32'd3);
    chk("s33b_best_len", best_len, 7);
    chk("s33b_core_raw_orbit", m_orbit, 14);

    run_sweep(32'd1, 32'd7);
    chk("s17_best_seed", best_seed, 7);
    chk("s17_best_len", best_len, 16);
    chk("s17_best_peak", best_peak, 52);

    for (int i = 0; i < 4; i++) begin
      f = $urandom_range(3000, 1);
      run_sweep(f, f + $urandom_range(8, 0));
    end
    f = $urandom_range(3000, 10);
    run_sweep(f, f - $urandom_range(5, 1));

    // start pulsed mid-run is ignored
    do_start(32'd27, 32'd27);
    wait_oe(1'b1, 50);
    repeat (5) @(negedge clk);
    do_start(32'd100, 32'd200);
    wait_idle(2000);
    chk("ign_done", done, 1);
    chk("ign_cur_seed", cur_seed, 27);
    chk("ign_best_seed", best_seed, 27);
    chk("ign_best_len", best_len, 111);
    chk("ign_best_peak", best_peak, 9232);

    // reset while reading back
    do_start(32'd5, 32'd5);
    wait_oe(1'b1, 50);
    wait_oe(1'b0, 200);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("rst_rd");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_rd_stays_idle", busy, 0);

    // overflow
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(500);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_done", done, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_timeout_flag", err_timeout, 0);
    chk("ovf_best_len", best_len, 0);
    do_start(32'd3, 32'd3);
    repeat (30) @(negedge clk);
    chk("ovf_start_ignored_busy", busy, 0);
    chk("ovf_start_ignored_seed", cur_seed, 32'hFFFF_FFFF);
    chk("ovf_flag_held", err_overflow, 1);
    do_reset();
    check_zero("ovf_reset");

    // timeout on a hung run
    do_start(32'd0, 32'd0);
    k = 0;
    while (!err_timeout && k < 1500) begin @(negedge clk); k++; end
    chk("to_flag", err_timeout, 1);
    chk("to_latency_in_range", (k >= 1000 && k <= 1012), 1);
    chk("to_busy", busy, 0);
    chk("to_done", done, 0);
    chk("to_ovf_flag", err_overflow, 0);
    do_reset();
    check_zero("to_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
